sonar_multi_hcsr04: RTL
=======================

# sonar_multi_hcsr04

Parametrised multi-channel HC-SR04 ultrasonic ranging engine for the sonar project, the successor to the single-channel sensor interface. On a rising edge of `medir`, it fires each sensor in turn, measures each echo pulse width, and converts it to centimetres. It flags channels that never answer and pulses `pronto` once the whole sweep is stored. Sensors are fired sequentially, never concurrently, to avoid acoustic crosstalk between adjacent transducers.

## Interface
- `N_CH`, 2: number of sensor channels (1..8)
- `CLK_HZ`, 50_000_000: system clock frequency
- `TRIG_US`, 10: trigger pulse width in µs; `TRIG_CYC = CLK_HZ/1_000_000*TRIG_US`
- `CM_CYC`, 2941: clock cycles of echo-high per centimetre (58.82 µs at 50 MHz)
- `TMO_CYC`, 1_500_000: per-channel timeout in cycles (30 ms), counted from trigger fall
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `medir`  in  1  start request; the sweep begins on its rising edge
- `echo`  in  N_CH  raw echo inputs (asynchronous)
- `trigger`  out  N_CH  trigger outputs, one-hot while active
- `medida`  out  12*N_CH  per-channel distance; channel k occupies bits [12k+11:12k]
- `timeout`  out  N_CH  per-channel no-echo flag for the last sweep
- `ocupado`  out  1  high from sweep start until `pronto`
- `pronto`  out  1  one-cycle pulse when the sweep completes

## Operation
- Input conditioning:
  - Each `echo` bit passes through a 2-FF synchroniser.
  - `medir` is registered once, and the edge detector compares it against its previous value.
- FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, STORE, NEXT, DONE. A channel index `ch` runs 0..N_CH-1.
- IDLE: on a `medir` rising edge, `ch`<=0 and the FSM goes to TRIG.
- TRIG: `trigger[ch]`=1 for exactly TRIG_CYC cycles, then the FSM goes to WAIT_ECHO and the timeout counter clears.
- WAIT_ECHO:
  - Synchronised echo high → MEASURE; the cm counter and sub-counter clear.
  - Timeout counter reaches TMO_CYC → STORE with the timeout flag set.
- MEASURE:
  - The sub-counter counts echo-high cycles. On reaching CM_CYC-1 it wraps and the cm counter increments.
  - The cm counter saturates at its maximum value (see Configuration).
  - Echo low → STORE.
  - Timeout counter reaches TMO_CYC → STORE with timeout set (stuck-high echo). The timeout counter keeps running through MEASURE.
- STORE:
  - Writes the cm value into the `medida` slice for `ch` and writes `timeout[ch]`.
  - A timed-out channel stores its saturation value.
  - Partial centimetres are truncated.
- NEXT: if `ch`==N_CH-1 → DONE; otherwise `ch`++ and the FSM goes to TRIG.
- DONE: `pronto`=1 for one cycle, then IDLE.
- A `medir` edge outside IDLE is ignored and is not queued.
- Echo activity on a non-selected channel is ignored.
- `medida`/`timeout` slices keep their last stored value until overwritten in the next sweep.

## Timing
- Reset value: every output is 0 and the FSM is in IDLE. This applies on any cycle, including mid-sweep, and an active trigger drops on the next edge.
- `ocupado` and `trigger[0]` rise 2 cycles after the `medir` rising edge at the pin: 1 cycle for the register, 1 for the FSM.
- Echo-to-measure latency is 2 cycles (synchroniser); it applies symmetrically to both edges, so the width is preserved.
- Echo falling at the pin → `medida` slice updated 4 cycles later: sync 2, MEASURE exit 1, STORE 1. `pronto` follows 2 cycles after the last channel's STORE.
- Timeout takes priority over echo if both occur in the same cycle.
- A simultaneous `reset` and `medir` edge: reset wins and no sweep starts.

## Configuration
- `SONAR_BCD_EN` defined:
  - The cm counter is 3-digit BCD and `medida` slices are BCD (hundreds in [11:8]).
  - Saturation value is 0x999.
- `SONAR_BCD_EN` undefined:
  - The cm counter is 12-bit binary.
  - Saturation value is 0xFFF (4095).
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset, then `medir` pulse; ch0 echo 294100 cycles high, ch1 echo 58820 cycles high. Required: `medida`=0x020_100 (BCD) / 0x014_064 (binary), `timeout`=00, one `pronto` pulse, `trigger` widths exactly 500 cycles each and never overlapping.
- ch1 echo never rises. Required: `timeout`=2'b10, ch1 slice = 0x999 / 0xFFF, `pronto` 1_500_000 cycles after trigger1 fall plus the fixed latency.
- Echo width 2940 cycles. Required: stores 0 (truncation). Echo 2941 cycles. Required: stores 1.
- Second `medir` edge during MEASURE. Required: ignored; exactly one `pronto` pulse.
- `reset` asserted mid-TRIG on ch1. Required: all outputs 0 next cycle, FSM back in IDLE; a new `medir` edge restarts cleanly from ch0.
- Echo held high forever on ch0. Required: timeout set, stored value saturated; the FSM proceeds to ch1.

Source files
------------

// File: rtl/sonar_multi_hcsr04_if.sv
// Interface bundling the ranging engine's request, echo and result signals.
// The engine connects to the slave modport, and the host or sensor side
// connects to the master modport.
interface sonar_multi_hcsr04_if #(
    parameter int N_CH = 2
);
    logic                 medir;
    logic [N_CH-1:0]      echo;
    logic [N_CH-1:0]      trigger;
    logic [12*N_CH-1:0]   medida;
    logic [N_CH-1:0]      timeout;
    logic                 ocupado;
    logic                 pronto;

    modport master (
        output medir,
        output echo,
        input  trigger,
        input  medida,
        input  timeout,
        input  ocupado,
        input  pronto
    );

    modport slave (
        input  medir,
        input  echo,
        output trigger,
        output medida,
        output timeout,
        output ocupado,
        output pronto
    );
endinterface

// File: rtl/sonar_multi_hcsr04.sv
// Multi-channel HC-SR04 ranging engine.
// A rising edge of medir starts a sweep. Each channel is triggered in turn,
// never concurrently. The echo width is converted to centimetres, and
// channels that do not answer are flagged.
// Build option SONAR_BCD_EN: when it is defined, the cm counter and the
// medida slices are 3-digit BCD and saturate at 0x999. Otherwise they are
// 12-bit binary and saturate at 0xFFF.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a medir rising edge
// S_TRIG     | trigger[ch] high for TRIG_CYC cycles
// S_WAIT_ECHO| trigger released, waiting for echo rise or timeout
// S_MEASURE  | echo high, counting centimetres
// S_STORE    | writing medida/timeout slice of ch
// S_NEXT     | advancing to the next channel or finishing
// S_DONE     | pronto pulse, back to idle
module sonar_multi_hcsr04 #(
    parameter int N_CH    = 2,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TRIG_US = 10,
    parameter int CM_CYC  = 2941,
    parameter int TMO_CYC = 1_500_000
) (
    input logic                 clock,
    input logic                 reset,
    sonar_multi_hcsr04_if.slave bus
);
    localparam int TRIG_CYC = CLK_HZ / 1_000_000 * TRIG_US;
    localparam int MAX_CYC  = (TRIG_CYC > TMO_CYC) ? TRIG_CYC : TMO_CYC;
    localparam int TMR_W    = $clog2(MAX_CYC + 1);
    localparam int SUB_W    = (CM_CYC > 1) ? $clog2(CM_CYC) : 1;
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

`ifdef SONAR_BCD_EN
    localparam logic [11:0] CM_SAT = 12'h999;
`else
    localparam logic [11:0] CM_SAT = 12'hFFF;
`endif

    // The cycle that detects the echo is itself an echo-high cycle. The
    // sub-counter therefore starts with that cycle already counted, so that
    // the measured width equals the pin width.
    localparam logic [11:0]      CM_ENTRY  = (CM_CYC > 1) ? 12'd0 : 12'd1;
    localparam logic [SUB_W-1:0] SUB_ENTRY = SUB_W'((CM_CYC > 1) ? 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_STORE,
        S_NEXT,
        S_DONE
    } state_t;

    // Input conditioning registers.
    logic              medir_s_q, medir_s_d;
    logic              medir_p_q, medir_p_d;
    logic [N_CH-1:0]   echo_m_q, echo_m_d;
    logic [N_CH-1:0]   echo_s_q, echo_s_d;

    // FSM state and registered outputs.
    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [11:0]       cm_q, cm_d;
    logic              tmo_hit_q, tmo_hit_d;
    logic [N_CH-1:0]   trigger_q, trigger_d;
    logic [12*N_CH-1:0] medida_q, medida_d;
    logic [N_CH-1:0]   timeout_q, timeout_d;
    logic              ocupado_q, ocupado_d;
    logic              pronto_q, pronto_d;

    logic              medir_rise;
    logic              echo_sel;
    logic              tmr_tc;
    logic [CH_W-1:0]   ch_inc;

    // Saturating increment of the cm counter, in binary or BCD.
    function automatic logic [11:0] cm_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != CM_SAT) begin
`ifdef SONAR_BCD_EN
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
`else
            r = v + 12'd1;
`endif
        end
        return r;
    endfunction

    // Next values of the medir edge register and the echo synchronisers.
    always_comb begin
        medir_s_d = bus.medir;
        medir_p_d = medir_s_q;
        echo_m_d  = bus.echo;
        echo_s_d  = echo_m_q;
    end

    // Input registers. While reset is active the previous medir value is
    // forced high. A medir level that is already high across reset is
    // therefore not taken as a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            medir_s_q <= medir_s_d;
            medir_p_q <= 1'b1;
            echo_m_q  <= '0;
            echo_s_q  <= '0;
        end else begin
            medir_s_q <= medir_s_d;
            medir_p_q <= medir_p_d;
            echo_m_q  <= echo_m_d;
            echo_s_q  <= echo_s_d;
        end
    end

    // Sweep sequencing: next state, counters and output registers.
    always_comb begin
        medir_rise = medir_s_q & ~medir_p_q;
        tmr_tc     = (tmr_q == '0);
        ch_inc     = ch_q + 1'b1;

        echo_sel = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == CH_W'(k)) echo_sel = echo_s_q[k];
        end

        state_d   = state_q;
        ch_d      = ch_q;
        tmr_d     = tmr_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        tmo_hit_d = tmo_hit_q;
        trigger_d = trigger_q;
        medida_d  = medida_q;
        timeout_d = timeout_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (medir_rise) begin
                    state_d   = S_TRIG;
                    ch_d      = '0;
                    tmr_d     = TMR_W'(TRIG_CYC - 1);
                    trigger_d = '0;
                    trigger_d[0] = 1'b1;
                    ocupado_d = 1'b1;
                end
            end
            S_TRIG: begin
                if (tmr_tc) begin
                    state_d   = S_WAIT_ECHO;
                    trigger_d = '0;
                    tmr_d     = TMR_W'(TMO_CYC - 1);
                    tmo_hit_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WAIT_ECHO: begin
                if (tmr_tc) begin
                    state_d   = S_STORE;
                    tmo_hit_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                    if (echo_sel) begin
                        state_d = S_MEASURE;
                        cm_d    = CM_ENTRY;
                        sub_d   = SUB_ENTRY;
                    end
                end
            end
            S_MEASURE: begin
                if (tmr_tc) begin
                    state_d   = S_STORE;
                    tmo_hit_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                    if (!echo_sel) begin
                        state_d = S_STORE;
                    end else if (sub_q == SUB_W'(CM_CYC - 1)) begin
                        sub_d = '0;
                        cm_d  = cm_inc(cm_q);
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            S_STORE: begin
                state_d = S_NEXT;
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_q == CH_W'(k)) begin
                        medida_d[12*k +: 12] = tmo_hit_q ? CM_SAT : cm_q;
                        timeout_d[k]         = tmo_hit_q;
                    end
                end
            end
            S_NEXT: begin
                if (ch_q == CH_W'(N_CH - 1)) begin
                    state_d   = S_DONE;
                    pronto_d  = 1'b1;
                    ocupado_d = 1'b0;
                end else begin
                    state_d   = S_TRIG;
                    ch_d      = ch_inc;
                    tmr_d     = TMR_W'(TRIG_CYC - 1);
                    trigger_d = '0;
                    for (int k = 0; k < N_CH; k++) begin
                        if (ch_inc == CH_W'(k)) trigger_d[k] = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM register bank. Reset clears every output in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            tmr_q     <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            tmo_hit_q <= 1'b0;
            trigger_q <= '0;
            medida_q  <= '0;
            timeout_q <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            tmr_q     <= tmr_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            tmo_hit_q <= tmo_hit_d;
            trigger_q <= trigger_d;
            medida_q  <= medida_d;
            timeout_q <= timeout_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign bus.trigger = trigger_q;
    assign bus.medida  = medida_q;
    assign bus.timeout = timeout_q;
    assign bus.ocupado = ocupado_q;
    assign bus.pronto  = pronto_q;
endmodule
